pipeline_hazard_ctrl: RTL and testbench

Central hazard and branch sequencer for the five-stage ARM pipeline. Takes the taken-branch and link requests produced by the ID-stage condition handling, the EX-stage load-use information and the data-memory busy flag. Drives PC source/load, the IF/ID and ID/EX register controls, and the link-register write strobe. It sits beside the ID-stage control unit and is the only block allowed to stall or flush the front end.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/branch sequencer: state encoding,
// register indices and the front-end control word with its NOP/reset value.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W_DEF = 4;
    localparam int PC_IDX    = 15;
    localparam int LR_IDX    = 14;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_ld;
        logic pc_sel;
        logic ifid_ld;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
        logic lr_wr;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{default: 1'b0};

    // Front end parked: IF/ID cleared, ID/EX gets NOP controls, nothing advances.
    localparam ctrl_t CTRL_NOP = '{pc_ld: 1'b0, pc_sel: 1'b0, ifid_ld: 1'b0,
                                   ifid_flush: 1'b1, idex_bubble: 1'b1,
                                   pipe_hold: 1'b0, lr_wr: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the EX load destination and the
// ID-stage source registers. A PC destination never creates a hazard.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    output logic             load_use
);

    logic rn_hit;
    logic rm_hit;

    assign rn_hit   = id_use_rn && (id_rn == ex_rd);
    assign rm_hit   = id_use_rm && (id_rm == ex_rd);
    assign load_use = ex_load && (ex_rd != REG_W'(PC_IDX)) && (rn_hit || rm_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and branch sequencer for the five-stage pipeline front end.
// Optional HAZ_STATS_EN adds saturating stall/flush statistics outputs.
//
// state | meaning
// RUN   | normal issue; load-use stalls and taken branches resolved here
// FLUSH | wrong-path slots after a taken branch being cleared from IF/ID
// HOLD  | data memory busy, whole pipe frozen; may carry a pending branch
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_W        = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t_address,
    input  logic             bl_reg,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             mem_busy,
    output logic             pc_ld,
    output logic             pc_sel,
    output logic             ifid_ld,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
`ifdef HAZ_STATS_EN
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt,
`endif
    output logic             lr_wr
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pend_take_q, pend_take_d;
    logic       pend_bl_q, pend_bl_d;
    logic       ret_flush_q, ret_flush_d;
    logic       load_use;
    logic       br_go;
    logic       br_link;
    ctrl_t      ctrl;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .ex_load   (ex_load),
        .ex_rd     (ex_rd),
        .id_rn     (id_rn),
        .id_rm     (id_rm),
        .id_use_rn (id_use_rn),
        .id_use_rm (id_use_rm),
        .load_use  (load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            pend_take_q <= 1'b0;
            pend_bl_q   <= 1'b0;
            ret_flush_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_take_q <= pend_take_d;
            pend_bl_q   <= pend_bl_d;
            ret_flush_q <= ret_flush_d;
        end
    end

    always_comb begin
        ctrl        = CTRL_IDLE;
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_take_d = pend_take_q;
        pend_bl_d   = pend_bl_q;
        ret_flush_d = ret_flush_q;
        br_go       = 1'b0;
        br_link     = 1'b0;

        if (mem_busy) begin
            ctrl.pipe_hold = 1'b1;
            if (state_q != HOLD) begin
                state_d     = HOLD;
                ret_flush_d = (state_q == FLUSH);
                if (state_q == RUN && t_address) begin
                    pend_take_d = 1'b1;
                    pend_bl_d   = bl_reg;
                end
            end
        end else if (state_q == HOLD && pend_take_q) begin
            br_go       = 1'b1;
            br_link     = pend_bl_q;
            pend_take_d = 1'b0;
            pend_bl_d   = 1'b0;
        end else if (state_q == FLUSH || (state_q == HOLD && ret_flush_q)) begin
            // Counter is frozen while held, so a released FLUSH resumes its slot count.
            ctrl.pc_ld      = 1'b1;
            ctrl.ifid_flush = 1'b1;
            cnt_d           = cnt_q - 3'd1;
            state_d         = (cnt_q == 3'd1) ? RUN : FLUSH;
        end else if (load_use) begin
            ctrl.idex_bubble = 1'b1;
            state_d          = RUN;
        end else if (t_address) begin
            br_go   = 1'b1;
            br_link = bl_reg;
        end else begin
            ctrl.pc_ld   = 1'b1;
            ctrl.ifid_ld = 1'b1;
            state_d      = RUN;
        end

        if (br_go) begin
            ctrl.pc_ld      = 1'b1;
            ctrl.pc_sel     = 1'b1;
            ctrl.ifid_flush = 1'b1;
            ctrl.lr_wr      = br_link;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_INIT;
            end else begin
                state_d = RUN;
            end
        end

        if (!rst_n) begin
            ctrl = CTRL_NOP;
        end
    end

    assign pc_ld       = ctrl.pc_ld;
    assign pc_sel      = ctrl.pc_sel;
    assign ifid_ld     = ctrl.ifid_ld;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign pipe_hold   = ctrl.pipe_hold;
    assign lr_wr       = ctrl.lr_wr;

`ifdef HAZ_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (ctrl.idex_bubble && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (ctrl.ifid_flush && flush_q != 16'hFFFF)  flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    // Statistics build option off: no counters exist.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl, three flush depths
// side by side against a slot-counting behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       t_address = 1'b0, bl_reg = 1'b0, ex_load = 1'b0, mem_busy = 1'b0;
    logic [3:0] ex_rd = '0, id_rn = '0, id_rm = '0;
    logic       id_use_rn = 1'b0, id_use_rm = 1'b0;

    logic [N-1:0] pc_ld, pc_sel, ifid_ld, ifid_flush, idex_bubble, pipe_hold, lr_wr;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt [N];
    logic [15:0] flush_cnt [N];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int fc_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        pipeline_hazard_ctrl #(.FLUSH_CYCLES((g == 0) ? 1 : ((g == 1) ? 2 : 4)), .REG_W(4)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .t_address   (t_address),
            .bl_reg      (bl_reg),
            .ex_load     (ex_load),
            .ex_rd       (ex_rd),
            .id_rn       (id_rn),
            .id_rm       (id_rm),
            .id_use_rn   (id_use_rn),
            .id_use_rm   (id_use_rm),
            .mem_busy    (mem_busy),
            .pc_ld       (pc_ld[g]),
            .pc_sel      (pc_sel[g]),
            .ifid_ld     (ifid_ld[g]),
            .ifid_flush  (ifid_flush[g]),
            .idex_bubble (idex_bubble[g]),
            .pipe_hold   (pipe_hold[g]),
`ifdef HAZ_STATS_EN
            .stall_cnt   (stall_cnt[g]),
            .flush_cnt   (flush_cnt[g]),
`endif
            .lr_wr       (lr_wr[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: remaining wrong-path slots, a pending branch, and whether last cycle was busy.
    int flush_left [N] = '{0, 0, 0};
    bit pend       [N] = '{0, 0, 0};
    bit pend_bl    [N] = '{0, 0, 0};
    bit busy_prev  [N] = '{0, 0, 0};
    int stalls     [N] = '{0, 0, 0};
    int flushes    [N] = '{0, 0, 0};
    int nx_flush_left [N] = '{0, 0, 0};
    bit nx_pend       [N] = '{0, 0, 0};
    bit nx_pend_bl    [N] = '{0, 0, 0};
    bit nx_busy_prev  [N] = '{0, 0, 0};
    int nx_stalls     [N] = '{0, 0, 0};
    int nx_flushes    [N] = '{0, 0, 0};

    // Vector order: pc_ld pc_sel ifid_ld ifid_flush idex_bubble pipe_hold lr_wr
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                logic [6:0] e;
                logic [6:0] a;
                int  fl;
                bit  pd, pb, lu;
                fl = flush_left[i];
                pd = pend[i];
                pb = pend_bl[i];
                lu = ex_load && (ex_rd != 4'd15) &&
                     ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
                if (!rst_n) begin
                    e = 7'b0001100; fl = 0; pd = 0; pb = 0;
                end else if (mem_busy) begin
                    e = 7'b0000010;
                    if (!busy_prev[i] && fl == 0 && t_address) begin
                        pd = 1; pb = bl_reg;
                    end
                end else if (pd) begin
                    e = {6'b110100, pb}; fl = fc_of(i) - 1; pd = 0; pb = 0;
                end else if (fl > 0) begin
                    e = 7'b1001000; fl--;
                end else if (lu) begin
                    e = 7'b0000100;
                end else if (t_address) begin
                    e = {6'b110100, bl_reg}; fl = fc_of(i) - 1;
                end else begin
                    e = 7'b1010000;
                end
                a = {pc_ld[i], pc_sel[i], ifid_ld[i], ifid_flush[i],
                     idex_bubble[i], pipe_hold[i], lr_wr[i]};
                chk($sformatf("ctrl_fc%0d", fc_of(i)), 32'(a), 32'(e));
`ifdef HAZ_STATS_EN
                chk($sformatf("stall_cnt_fc%0d", fc_of(i)), 32'(stall_cnt[i]), 32'(stalls[i]));
                chk($sformatf("flush_cnt_fc%0d", fc_of(i)), 32'(flush_cnt[i]), 32'(flushes[i]));
`endif
                nx_flush_left[i] = fl;
                nx_pend[i]       = pd;
                nx_pend_bl[i]    = pb;
                nx_busy_prev[i]  = rst_n && mem_busy;
                if (!rst_n) begin
                    nx_stalls[i]  = 0;
                    nx_flushes[i] = 0;
                end else begin
                    nx_stalls[i]  = (e == 7'b0000100 && stalls[i] < 65535) ? stalls[i] + 1 : stalls[i];
                    nx_flushes[i] = (e[3] && flushes[i] < 65535) ? flushes[i] + 1 : flushes[i];
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            flush_left[i] = nx_flush_left[i];
            pend[i]       = nx_pend[i];
            pend_bl[i]    = nx_pend_bl[i];
            busy_prev[i]  = nx_busy_prev[i];
            stalls[i]     = nx_stalls[i];
            flushes[i]    = nx_flushes[i];
        end
    end

    task automatic idle();
        t_address = 0; bl_reg = 0; ex_load = 0; mem_busy = 0;
        ex_rd = 0; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed sequence, literal checks on the FLUSH_CYCLES=2 instance.
        rst_n = 0; idle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_ifid_flush", 32'(ifid_flush[1]), 1);
        chk("rst_idex_bubble", 32'(idex_bubble[1]), 1);
        chk("rst_pc_ld", 32'(pc_ld[1]), 0);
        chk("rst_lr_wr", 32'(lr_wr[1]), 0);
        next_cycle();

        rst_n = 1;
        @(negedge clk);
        chk("run_pc_ld", 32'(pc_ld[1]), 1);
        chk("run_ifid_ld", 32'(ifid_ld[1]), 1);
        next_cycle();

        t_address = 1; bl_reg = 1;
        @(negedge clk);
        chk("bl_pc_sel", 32'(pc_sel[1]), 1);
        chk("bl_lr_wr", 32'(lr_wr[1]), 1);
        chk("bl_flush0", 32'(ifid_flush[1]), 1);
        next_cycle();
        @(negedge clk);
        chk("bl_flush1", 32'(ifid_flush[1]), 1);
        chk("flush_ignores_t", 32'({pc_sel[1], lr_wr[1]}), 0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("after_flush", 32'({ifid_flush[1], ifid_ld[1]}), 32'b01);
        next_cycle();

        ex_load = 1; ex_rd = 3; id_rn = 3; id_use_rn = 1; t_address = 1;
        @(negedge clk);
        chk("lu_pc_ld", 32'(pc_ld[1]), 0);
        chk("lu_bubble", 32'(idex_bubble[1]), 1);
        next_cycle();
        ex_load = 0;
        @(negedge clk);
        chk("lu_branch_next", 32'({pc_ld[1], pc_sel[1], idex_bubble[1]}), 32'b110);
        next_cycle();
        idle();
        next_cycle();

        ex_load = 1; ex_rd = 15; id_rn = 15; id_use_rn = 1;
        @(negedge clk);
        chk("r15_no_stall", 32'({idex_bubble[1], pc_ld[1]}), 32'b01);
        next_cycle();

        idle(); mem_busy = 1; t_address = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold_%0d", k), 32'({pipe_hold[1], pc_ld[1]}), 32'b10);
            next_cycle();
            t_address = 0;
        end
        mem_busy = 0;
        @(negedge clk);
        chk("hold_release", 32'({pc_sel[1], ifid_flush[1], pipe_hold[1], lr_wr[1]}), 32'b1100);
        next_cycle();
        next_cycle();
        next_cycle();

        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            t_address = ($urandom_range(0, 3) == 0);
            bl_reg    = $urandom_range(0, 1) == 1;
            ex_load   = ($urandom_range(0, 2) == 0);
            ex_rd     = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            id_rn     = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            id_rm     = 4'($urandom_range(0, 3));
            id_use_rn = $urandom_range(0, 1) == 1;
            id_use_rm = $urandom_range(0, 1) == 1;
            mem_busy  = ($urandom_range(0, 5) == 0);
            next_cycle();
        end

`ifdef HAZ_STATS_EN
        rst_n = 0; idle();
        next_cycle();
        rst_n = 1; ex_load = 1; ex_rd = 3; id_rn = 3; id_use_rn = 1;
        for (int c = 0; c < 70000; c++) next_cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("stall_sat", 32'(stall_cnt[i]), 32'h0000FFFF);
`endif

        idle();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
